// File: rtl/mips_pkg.sv
// Shared loader definitions: FSM state encoding and boot stream format constants.
package mips_pkg;

  // Loader FSM states; CSUM is only reachable when the checksum trailer is built in.
  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

  // Stream format: big-endian 16-bit word count, then 4 bytes per word.
  localparam int COUNT_BYTES    = 2;
  localparam int COUNT_W        = 8 * COUNT_BYTES;
  localparam int BYTES_PER_WORD = 4;

  // States in which the loader is willing to take a stream byte.
  function automatic logic accepts_bytes(loader_state_t s);
    return (s == CNT_HI) || (s == CNT_LO) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream input, instruction-memory write port and core hold/status for imem_loader.
interface imem_loader_if #(
  parameter int AW = 32
);
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;

  // The loader consumes the stream and drives the memory port and status.
  modport loader (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, error
  );

  // The byte source / system side.
  modport host (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted stream bytes into big-endian 32-bit words (first byte -> [31:24]).
module word_assembler
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        word_ready_o,
  output logic [31:0] word_o
);

  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam int SW = 8 * (BYTES_PER_WORD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] shift_q, shift_d;

  // Shift in each accepted byte; the counter wraps naturally after the last byte of a word.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (byte_en_i) begin
      cnt_d   = cnt_q + 1'b1;
      shift_d = {shift_q[SW-9:0], byte_i};
    end
  end

  // Byte counter and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // The word is complete in the same cycle its final byte is presented.
  assign word_ready_o = byte_en_i && (cnt_q == CW'(BYTES_PER_WORD - 1));
  assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction loader: receives a counted big-endian word stream, writes it to
// instruction memory at PC byte addresses and holds the core in reset until complete.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
  import mips_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.loader bus
);

  localparam int IW = $clog2(DEPTH + 1);

  loader_state_t      state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] count_eval;
  logic [IW-1:0]      index_q, index_d;
  logic               we_q, we_d;
  logic [AW-1:0]      waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               hold_q, hold_d;
  logic               accept;
  logic               asm_en;
  logic               last_word;
  logic               word_ready;
  logic [31:0]        word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  assign bus.byte_ready = accepts_bytes(state_q);
  assign accept         = bus.byte_valid && bus.byte_ready;
  assign asm_en         = accept && (state_q == DATA);

  word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .byte_en_i    (asm_en),
    .byte_i       (bus.byte_data),
    .word_ready_o (word_ready),
    .word_o       (word)
  );

  // Next-state logic: count capture, word writes, terminal decisions and release/error flags.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    index_d    = index_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    count_eval = {count_q[COUNT_W-1:8], bus.byte_data};
    last_word  = (32'(index_q) + 32'd1) == 32'(count_q);
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      CNT_HI: begin
        if (accept) begin
          count_d = {bus.byte_data, count_q[COUNT_W-9:0]};
          state_d = CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept) begin
          count_d = count_eval;
          if (count_eval == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else if (32'(count_eval) > 32'(DEPTH)) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) begin
          csum_d = csum_q ^ bus.byte_data;
        end
`endif
        if (word_ready) begin
          we_d    = 1'b1;
          waddr_d = AW'({index_q, 2'b00});
          wdata_d = word;
          index_d = index_q + 1'b1;
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (accept) begin
          state_d = (bus.byte_data == csum_q) ? DONE : ERROR;
        end
      end
`endif
      default: begin
        state_d = state_q;
      end
    endcase
    // Release waits one cycle behind the final write strobe so the last word lands first.
    done_d  = (state_d == DONE) && !we_d;
    error_d = (state_d == ERROR);
    hold_d  = !done_d;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CNT_HI;
      count_q <= '0;
      index_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of the data bytes of the current image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.cpu_hold   = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes and release/error
// cycles; a negedge monitor pops and compares whenever the loader presents a write.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.loader)
  );

  wr_t         exp_q[$];
  logic [7:0]  stream[$];
  logic [31:0] words[$];
  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int exp_done_cyc = -1;
  int exp_err_cyc = -1;
  bit done_seen = 0;
  bit err_seen = 0;

  function automatic logic [7:0] wbyte(input logic [31:0] w, input int j);
    return w[31-8*j -: 8];
  endfunction

  // Monitor: pops the scoreboard on each write strobe and times done/error rises.
  always @(negedge clk) begin
    wr_t w;
    ncyc <= ncyc + 1;
    if (!reset) begin
      if (bus.imem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%h data=%h, none expected", bus.imem_waddr, bus.imem_wdata);
        end else begin
          w = exp_q.pop_front();
          if (bus.imem_waddr !== w.addr || bus.imem_wdata !== w.data) begin
            errors++;
            $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                     bus.imem_waddr, bus.imem_wdata, w.addr, w.data);
          end else begin
            $display("write addr=%h data=%h ok", w.addr, w.data);
          end
        end
      end
      checks++;
      if (bus.done && bus.error) begin
        errors++;
        $display("FAIL done_and_error: both high at cycle %0d", ncyc);
      end
      checks++;
      if (bus.cpu_hold !== !bus.done) begin
        errors++;
        $display("FAIL hold_vs_done: cpu_hold=%b done=%b, expected cpu_hold=~done", bus.cpu_hold, bus.done);
      end
      if (bus.done && !done_seen) begin
        done_seen = 1;
        checks++;
        if (ncyc != exp_done_cyc) begin
          errors++;
          $display("FAIL done_timing: rose at cycle %0d, expected %0d", ncyc, exp_done_cyc);
        end
      end
      if (bus.error && !err_seen) begin
        err_seen = 1;
        checks++;
        if (ncyc != exp_err_cyc) begin
          errors++;
          $display("FAIL error_timing: rose at cycle %0d, expected %0d", ncyc, exp_err_cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    done_seen    = 0;
    err_seen     = 0;
    exp_done_cyc = -1;
    exp_err_cyc  = -1;
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
    check("rst_imem_we", 32'(bus.imem_we), 32'd0);
    check("rst_imem_waddr", bus.imem_waddr, 32'd0);
    check("rst_imem_wdata", bus.imem_wdata, 32'd0);
    check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    reset = 1'b0;
  endtask

  // Drives the stream; when byte mark_idx is driven, records when done/error must rise.
  task automatic send_stream(input bit gap, input int mark_idx, input int lat, input bit is_err);
    foreach (stream[i]) begin
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_data  = stream[i];
      if (i == mark_idx) begin
        if (is_err) exp_err_cyc = ncyc + lat;
        else        exp_done_cyc = ncyc + lat;
      end
      if (gap) begin
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  // Reference model: builds the stream from n and words[], queues the expected writes
  // and the expected terminal outcome, then drives it with 'extra' ignored trailing bytes.
  task automatic run_load(input int n, input bit gap, input bit bad_csum, input int extra);
    logic [7:0] cs;
    wr_t        e;
    int         mark;
    int         lat;
    bit         want_err;
    cs = 8'h00;
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    if (n > DEPTH) begin
      mark     = 1;
      lat      = 1;
      want_err = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        for (int j = 0; j < 4; j++) begin
          stream.push_back(wbyte(words[i], j));
          cs ^= wbyte(words[i], j);
        end
        e.addr = AW'(i * 4);
        e.data = words[i];
        exp_q.push_back(e);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      stream.push_back(bad_csum ? (cs ^ 8'h01) : cs);
      mark     = stream.size() - 1;
      lat      = 1;
      want_err = bad_csum;
`else
      mark     = stream.size() - 1;
      lat      = (n == 0) ? 1 : 2;
      want_err = 0;
`endif
    end
    for (int k = 0; k < extra; k++) stream.push_back(8'($urandom));
    send_stream(gap, mark, lat, want_err);
    repeat (6) @(negedge clk);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    check("done_flag", 32'(done_seen), 32'(!want_err));
    check("error_flag", 32'(err_seen), 32'(want_err));
    check("final_ready", 32'(bus.byte_ready), 32'd0);
    check("final_hold", 32'(bus.cpu_hold), 32'(want_err));
    $display("load n=%0d gap=%0b bad_csum=%0b -> done=%0b error=%0b", n, gap, bad_csum, bus.done, bus.error);
    exp_q.delete();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    do_reset();

    // Two-word image, back-to-back, then with valid toggling.
    words = '{32'h20080005, 32'h00000008};
    run_load(2, 0, 0, 0);
    do_reset();
    run_load(2, 1, 0, 3);

    // Oversized count is rejected; trailing bytes are ignored.
    do_reset();
    words.delete();
    run_load(257, 0, 0, 4);

    // Reset after 6 data bytes of a 3-word load, then a fresh 1-word load.
    do_reset();
    words = '{$urandom, $urandom, $urandom};
    stream.delete();
    stream.push_back(8'h00);
    stream.push_back(8'h03);
    for (int j = 0; j < 6; j++) stream.push_back(wbyte(words[j/4], j % 4));
    exp_q.push_back('{addr: 32'h0, data: words[0]});
    send_stream(0, -1, 0, 0);
    repeat (3) @(negedge clk);
    check("partial_writes", 32'(exp_q.size()), 32'd0);
    check("partial_hold", 32'(bus.cpu_hold), 32'd1);
    do_reset();
    words = '{$urandom};
    run_load(1, 0, 0, 0);

    // Empty image.
    do_reset();
    words.delete();
    run_load(0, 0, 0, 2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    run_load(0, 0, 1, 0);
`endif

    // Single known word, good and (when built in) bad checksum.
    do_reset();
    words = '{32'h12345678};
    run_load(1, 0, 0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    run_load(1, 0, 1, 0);
`endif

    // Full-capacity image.
    do_reset();
    words.delete();
    for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
    run_load(DEPTH, 0, 0, 0);

    // Randomized images, gaps and occasional oversize counts.
    for (int t = 0; t < 10; t++) begin
      do_reset();
      words.delete();
      if ($urandom_range(0, 4) == 0) n = $urandom_range(DEPTH + 1, 65535);
      else n = $urandom_range(1, 8);
      if (n <= DEPTH) for (int i = 0; i < n; i++) words.push_back($urandom);
      run_load(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
